btn_req_queue: RTL and testbench
================================

Name: btn_req_queue

Overview:
- Parametrised successor of the single-request button front end.
- Debounces N_BTN pedestrian and vehicle request buttons, detects presses, and queues up to QUEUE_DEPTH distinct requests in arrival order.
- Drops duplicates and presents the oldest request to the traffic FSM as jump_req/jump_state.
- Sits between board button pins and the FSM override input.

Parameters:
- F_CLK_HZ, 50_000_000, clock frequency in Hz.
- T_DEBOUNCE_MS, 20, required stable time in ms; DEBOUNCE_CYC = (F_CLK_HZ/1000)*T_DEBOUNCE_MS.
- N_BTN, 12, number of buttons; legal range 1..16.
- QUEUE_DEPTH, 4, request FIFO entries; power of two, legal range 2..16.
- TIMEOUT_CYC, 500_000_000, head-request lifetime in cycles; used only with BTN_REQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  asynchronous raw buttons, active-high.
- accept_jump  in  1  FSM pulse: head request consumed.
- jump_req  out  1  queue non-empty.
- jump_state  out  tl_pkg::state_t  target state of the head entry.
- jump_idx  out  4  button index of the head entry.
- q_count  out  $clog2(QUEUE_DEPTH)+1  number of occupied entries.
- drop_pulse  out  1  one-cycle pulse when a new request is lost because the queue is full.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst: every register is cleared on the clk edge where rst=1. rst asserted mid-operation flushes the queue, the hold mask, and the debounce state.
- Reset values: jump_req=0, jump_state=S8_OVERRIDE, jump_idx=0, q_count=0, drop_pulse=0.
- Per-button debounce: 2-flop synchroniser, then a counter. The debounced output changes only after the synchronised input differs from it for DEBOUNCE_CYC consecutive cycles. The counter clears whenever the input returns to the current debounced value.
- Press detection: btn_rise = db & ~db_q, registered once.
- Hold mask: rise bits OR into hold[N_BTN-1:0], so simultaneous presses are never lost.
- Candidate selection: each cycle, the lowest set index of hold is the candidate.
  - At most one enqueue per cycle.
  - The candidate bit in hold clears once it is enqueued, merged or dropped.
- Duplicate merge: if the candidate index is already present in the queue (pending[idx]=1), it is merged. No enqueue and no drop_pulse.
- Full queue: if the queue is full and no pop occurs this cycle, the candidate is dropped and drop_pulse=1 for one cycle.
- Simultaneous pop and push: if the queue is full and accept_jump pops in the same cycle, the push succeeds and q_count is unchanged.
- Pop: accept_jump pops only when jump_req=1. accept_jump while empty is ignored. A pop clears pending[head idx].
- Re-press after pop: a re-press of a button just popped can be enqueued again in the cycle after the pop.
- Pointers: rd/wr pointers are $clog2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH. Full and empty are derived from q_count.
- Outputs: jump_req, jump_state and jump_idx are combinational from head registers.
  - jump_state = tl_pkg::btn_target(jump_idx) when non-empty, else S8_OVERRIDE.
- Latency: jump_req rises 2 cycles after db rises (rise register, then FIFO write), assuming an empty queue and a lone button.
- No internal state machine beyond the FIFO occupancy. States are EMPTY/PARTIAL/FULL, tracked through q_count.

Optional Feature:
- Macro: BTN_REQ_TIMEOUT_EN.
- When defined:
  - A head-age counter runs while jump_req=1 and resets on every pop or head change.
  - On reaching TIMEOUT_CYC-1 without accept_jump, the head is auto-popped: pending cleared, q_count decremented, drop_pulse asserted for that cycle.
  - accept_jump in the same cycle takes precedence; this counts as a normal pop with no drop_pulse.
- When undefined: entries wait indefinitely, and the counter and TIMEOUT_CYC logic are absent.

Decomposition:
- Shared in tl_pkg:
  - state_t, code_t.
  - Button index map: 0 B-W ped, 1 B-W left, 2 B-W straight, 3 B-E ped, 4 B-E left, 5 B-E straight, 6 A-S ped, 7 A-S left, 8 A-S straight, 9 A-N ped, 10 A-N left, 11 A-N straight.
  - Function btn_target(idx): B ped/straight -> S4_B_STRAIGHT, B left -> S6_B_LEFT, A ped/straight -> S0_A_STRAIGHT, A left -> S2_A_LEFT, idx>=12 -> S8_OVERRIDE.
- One sub-module: debounce_sync_sr, the sync-reset synchroniser plus debounce counter, instantiated N_BTN times.

Test Plan (all scenarios: F_CLK_HZ=1000, T_DEBOUNCE_MS=4 so DEBOUNCE_CYC=4; N_BTN=12, QUEUE_DEPTH=4):
1. Press btn 7 and hold 10 cycles -> jump_req=1 with jump_state=S2_A_LEFT, jump_idx=7, q_count=1; accept_jump pulse -> jump_req=0 on the next cycle.
2. Glitch btn 2 high for 3 cycles -> no request; hold 4 or more cycles -> exactly one entry.
3. Buttons 5, 1 and 9 rise in the same cycle -> enqueued on consecutive cycles in order 1, 5, 9; q_count=3; successive pops yield S6_B_LEFT, S4_B_STRAIGHT, S0_A_STRAIGHT.
4. Press btn 0, release, press again before any pop -> q_count stays 1 and drop_pulse=0.
5. Fill with buttons 0, 4, 6, 10, then press 11 -> drop_pulse=1, q_count=4; repeat with accept_jump in the push cycle -> 11 enqueued, q_count stays 4.
6. Assert rst for 1 cycle with 3 entries queued -> all outputs at reset values on the next cycle. With BTN_REQ_TIMEOUT_EN and TIMEOUT_CYC=20, an unaccepted head is popped after 20 cycles with drop_pulse=1.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared traffic-light types and the button-index to target-phase map.
// Used by the button request front end and the traffic FSM.
package tl_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [3:0] {
    S0_A_STRAIGHT,
    S1_A_YELLOW,
    S2_A_LEFT,
    S3_A_LEFT_YELLOW,
    S4_B_STRAIGHT,
    S5_B_YELLOW,
    S6_B_LEFT,
    S7_B_LEFT_YELLOW,
    S8_OVERRIDE
  } state_t;

  typedef enum logic [1:0] {
    C_RED,
    C_YELLOW,
    C_GREEN,
    C_OFF
  } code_t;

  // Pedestrian and straight requests share the straight phase of their road.
  function automatic state_t btn_target(input logic [IDX_W-1:0] idx);
    state_t s;
    case (idx)
      4'd1, 4'd4:              s = S6_B_LEFT;
      4'd0, 4'd2, 4'd3, 4'd5:  s = S4_B_STRAIGHT;
      4'd7, 4'd10:             s = S2_A_LEFT;
      4'd6, 4'd8, 4'd9, 4'd11: s = S0_A_STRAIGHT;
      default:                 s = S8_OVERRIDE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/debounce_sync_sr.sv
// Two-flop synchroniser plus stability counter for one button.
// Output follows the input after DEBOUNCE_CYC+2 cycles of stability; no backpressure.
module debounce_sync_sr #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_db
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      // Any agreement with the current level restarts the stability window.
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/btn_req_queue.sv
// Debounced button press queue feeding the FSM override; BTN_REQ_TIMEOUT_EN adds head expiry.
// jump_req 2 cycles after debounced rise; full queue drops new requests with drop_pulse.
module btn_req_queue
  import tl_pkg::*;
#(
  parameter int F_CLK_HZ      = 50_000_000,
  parameter int T_DEBOUNCE_MS = 20,
  parameter int N_BTN         = 12,
  parameter int QUEUE_DEPTH   = 4
`ifdef BTN_REQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 500_000_000
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BTN-1:0]             btn_raw,
  input  logic                         accept_jump,
  output logic                         jump_req,
  output state_t                       jump_state,
  output logic [IDX_W-1:0]             jump_idx,
  output logic [$clog2(QUEUE_DEPTH):0] q_count,
  output logic                         drop_pulse
);

  localparam int DEBOUNCE_CYC = (F_CLK_HZ / 1000) * T_DEBOUNCE_MS;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [N_BTN-1:0] w_db;
  logic [N_BTN-1:0] r_db_q;
  logic [N_BTN-1:0] r_rise;
  logic [N_BTN-1:0] r_hold;
  logic [15:0]      r_pending;
  logic [IDX_W-1:0] r_mem [QUEUE_DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             r_drop;

  logic [N_BTN-1:0] w_pool;
  logic [N_BTN-1:0] w_cand_mask;
  logic             w_cand_vld;
  logic [IDX_W-1:0] w_cand_idx;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_full;
  logic             w_dup;
  logic             w_tout;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [15:0]      w_pop_mask;
  logic [15:0]      w_push_mask;

  for (genvar g = 0; g < N_BTN; g++) begin : g_db
    debounce_sync_sr #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .i_clk (clk),
      .i_rst (rst),
      .i_raw (btn_raw[g]),
      .o_db  (w_db[g])
    );
  end

  // Fresh rises join the pool in the same cycle they are registered.
  assign w_pool      = r_hold | r_rise;
  assign w_cand_vld  = |w_pool;
  assign w_cand_mask = w_pool & ~(w_pool - N_BTN'(1));

  always_comb begin
    w_cand_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_pool[i]) w_cand_idx = IDX_W'(i);
    end
  end

  assign w_head_idx = r_mem[r_rd];
  assign w_full     = (r_count == CW'(QUEUE_DEPTH));
  assign w_dup      = r_pending[w_cand_idx];
  assign w_pop      = (accept_jump & jump_req) | w_tout;
  assign w_push     = w_cand_vld & ~w_dup & (~w_full | w_pop);
  assign w_drop     = (w_cand_vld & ~w_dup & w_full & ~w_pop) | w_tout;

  assign w_pop_mask  = w_pop  ? (16'd1 << w_head_idx) : 16'd0;
  assign w_push_mask = w_push ? (16'd1 << w_cand_idx) : 16'd0;

`ifdef BTN_REQ_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYC + 1);
  logic [AW-1:0] r_age;

  // Accept in the expiry cycle wins, so expiry is only a fallback pop.
  assign w_tout = jump_req & ~accept_jump & (r_age == AW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else if (w_pop || !jump_req) begin
      r_age <= '0;
    end else begin
      r_age <= r_age + AW'(1);
    end
  end
`else
  assign w_tout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_q    <= '0;
      r_rise    <= '0;
      r_hold    <= '0;
      r_pending <= '0;
      r_rd      <= '0;
      r_wr      <= '0;
      r_count   <= '0;
      r_drop    <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_db_q    <= w_db;
      r_rise    <= w_db & ~r_db_q;
      r_hold    <= w_pool & ~w_cand_mask;
      r_pending <= (r_pending & ~w_pop_mask) | w_push_mask;
      r_drop    <= w_drop;
      if (w_push) begin
        r_mem[r_wr] <= w_cand_idx;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign jump_req   = (r_count != '0);
  assign jump_idx   = jump_req ? w_head_idx : '0;
  assign jump_state = jump_req ? btn_target(w_head_idx) : S8_OVERRIDE;
  assign q_count    = r_count;
  assign drop_pulse = r_drop;

endmodule

// File: tb/tb_btn_req_queue.sv
// Bench for btn_req_queue: directed scenarios plus random presses against a queue model.
module tb_btn_req_queue;
  import tl_pkg::*;

  localparam int N  = 12;
  localparam int QD = 4;
`ifdef BTN_REQ_TIMEOUT_EN
  localparam int TO = 20;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         btn_raw = '0;
  logic                 accept_jump = 1'b0;
  logic                 jump_req;
  state_t               jump_state;
  logic [3:0]           jump_idx;
  logic [$clog2(QD):0]  q_count;
  logic                 drop_pulse;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int drop_seen = 0;

  btn_req_queue #(
    .F_CLK_HZ(1000), .T_DEBOUNCE_MS(4), .N_BTN(N), .QUEUE_DEPTH(QD)
`ifdef BTN_REQ_TIMEOUT_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .accept_jump(accept_jump),
    .jump_req(jump_req), .jump_state(jump_state), .jump_idx(jump_idx),
    .q_count(q_count), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  state_t tgt [12] = '{S4_B_STRAIGHT, S6_B_LEFT, S4_B_STRAIGHT,
                       S4_B_STRAIGHT, S6_B_LEFT, S4_B_STRAIGHT,
                       S0_A_STRAIGHT, S2_A_LEFT, S0_A_STRAIGHT,
                       S0_A_STRAIGHT, S2_A_LEFT, S0_A_STRAIGHT};

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, exp);
  endtask

  // Reference model: raw history, window debounce, request pool and an arrival-order queue.
  int           mq[$];
  logic [N-1:0] rawq[$];
  logic [N-1:0] m_db, m_early, m_late, m_hold;
  bit           m_drop;
  int           m_age;

  always @(posedge clk) begin
    logic [N-1:0] pool, win, nd;
    int c, sz;
    bit pop, tout, dup, push, drop;
    if (rst) begin
      mq.delete();
      rawq.delete();
      for (int i = 0; i < 6; i++) rawq.push_back('0);
      m_db = '0; m_early = '0; m_late = '0; m_hold = '0;
      m_drop = 1'b0; m_age = 0;
    end else begin
      rawq.push_back(btn_raw);
      if (rawq.size() > 8) void'(rawq.pop_front());
      sz   = mq.size();
      pop  = accept_jump && (sz > 0);
      tout = 1'b0;
`ifdef BTN_REQ_TIMEOUT_EN
      tout = !pop && (sz > 0) && (m_age == TO - 1);
`endif
      m_age = (pop || tout || sz == 0) ? 0 : m_age + 1;
      pool = m_hold | m_late;
      c = -1;
      for (int i = N - 1; i >= 0; i--) if (pool[i]) c = i;
      dup = 1'b0; push = 1'b0; drop = 1'b0;
      if (c >= 0) begin
        pool[c] = 1'b0;
        foreach (mq[k]) if (mq[k] == c) dup = 1'b1;
        if (!dup) begin
          if (sz < QD || pop || tout) push = 1'b1;
          else drop = 1'b1;
        end
      end
      m_hold = pool;
      if (pop || tout) void'(mq.pop_front());
      if (push) mq.push_back(c);
      m_drop = drop || tout;
      // Synchronised sample is the raw value from two edges back; flip after 4 disagreeing samples.
      win = '1;
      for (int k = 3; k <= 6; k++) win &= rawq[rawq.size() - k] ^ m_db;
      nd = m_db ^ win;
      m_late  = m_early;
      m_early = nd & ~m_db;
      m_db    = nd;
    end
  end

  always @(negedge clk) begin
    int e_cnt, head;
    bit ok;
    state_t e_state;
    if (chk_en) begin
      e_cnt = mq.size();
      head = 0;
      e_state = S8_OVERRIDE;
      if (e_cnt > 0) begin
        head = mq[0];
        e_state = tgt[head];
      end
      ok = (jump_req == (e_cnt > 0)) && (int'(q_count) == e_cnt) &&
           (drop_pulse == m_drop) && (jump_state == e_state) &&
           (e_cnt == 0 || int'(jump_idx) == head);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL model_cycle t=%0t req=%0b/%0b cnt=%0d/%0d idx=%0d/%0d state=%0d/%0d drop=%0b/%0b",
                    $time, jump_req, e_cnt > 0, q_count, e_cnt, jump_idx, head,
                    jump_state, e_state, drop_pulse, m_drop);
      if (drop_pulse) drop_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_accept();
    accept_jump = 1'b1;
    @(negedge clk);
    accept_jump = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req"},   int'(jump_req), 0);
    check({tag, "_state"}, int'(jump_state), int'(S8_OVERRIDE));
    check({tag, "_idx"},   int'(jump_idx), 0);
    check({tag, "_cnt"},   int'(q_count), 0);
    check({tag, "_drop"},  int'(drop_pulse), 0);
  endtask

  int hcnt [N];
  int d0;
  int n_hi;
  bit fell;

  initial begin
    for (int b = 0; b < N; b++) hcnt[b] = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check_reset("rst0");

    // 1: single press of A-S left
    btn_raw[7] = 1'b1;
    idle(10);
    check("s1_req", int'(jump_req), 1);
    check("s1_state", int'(jump_state), int'(S2_A_LEFT));
    check("s1_idx", int'(jump_idx), 7);
    check("s1_cnt", int'(q_count), 1);
    btn_raw[7] = 1'b0;
    pulse_accept();
    check("s1_pop_req", int'(jump_req), 0);
    idle(10);

    // 2: short glitch is filtered, real press is taken once
    btn_raw[2] = 1'b1;
    idle(3);
    btn_raw[2] = 1'b0;
    idle(12);
    check("s2_glitch_cnt", int'(q_count), 0);
    btn_raw[2] = 1'b1;
    idle(6);
    btn_raw[2] = 1'b0;
    idle(6);
    check("s2_cnt", int'(q_count), 1);
    check("s2_idx", int'(jump_idx), 2);
    pulse_accept();
    idle(10);

    // 3: simultaneous rises are queued lowest index first
    btn_raw[1] = 1'b1; btn_raw[5] = 1'b1; btn_raw[9] = 1'b1;
    idle(11);
    btn_raw = '0;
    check("s3_cnt", int'(q_count), 3);
    check("s3_state0", int'(jump_state), int'(S6_B_LEFT));
    pulse_accept();
    check("s3_state1", int'(jump_state), int'(S4_B_STRAIGHT));
    check("s3_idx1", int'(jump_idx), 5);
    pulse_accept();
    check("s3_state2", int'(jump_state), int'(S0_A_STRAIGHT));
    check("s3_idx2", int'(jump_idx), 9);
    pulse_accept();
    check("s3_empty", int'(q_count), 0);
    idle(10);

    // 4: re-press of a pending button merges
    d0 = drop_seen;
    btn_raw[0] = 1'b1; idle(6);
    btn_raw[0] = 1'b0; idle(8);
    btn_raw[0] = 1'b1; idle(6);
    btn_raw[0] = 1'b0; idle(8);
    check("s4_cnt", int'(q_count), 1);
    check("s4_drops", drop_seen - d0, 0);
    pulse_accept();
    idle(10);

    // 5: full queue drops, then a pop in the push cycle lets the request in
    btn_raw[0] = 1'b1; btn_raw[4] = 1'b1; btn_raw[6] = 1'b1; btn_raw[10] = 1'b1;
    idle(12);
    btn_raw = '0;
    idle(4);
    check("s5_full", int'(q_count), 4);
    d0 = drop_seen;
    btn_raw[11] = 1'b1; idle(10);
    btn_raw[11] = 1'b0; idle(10);
    check("s5_drop_cnt", int'(q_count), 4);
    check("s5_drops", drop_seen - d0, 1);
    check("s5_head", int'(jump_idx), 0);
    d0 = drop_seen;
    btn_raw[11] = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    accept_jump = 1'b1;
    @(negedge clk);
    accept_jump = 1'b0;
    idle(2);
    btn_raw[11] = 1'b0;
    check("s5_swap_cnt", int'(q_count), 4);
    check("s5_swap_head", int'(jump_idx), 4);
    check("s5_swap_drops", drop_seen - d0, 0);
    idle(8);
    repeat (4) pulse_accept();
    check("s5_drained", int'(q_count), 0);
    idle(10);

    // 6: reset flushes a partly filled queue
    btn_raw[1] = 1'b1; btn_raw[2] = 1'b1; btn_raw[3] = 1'b1;
    idle(12);
    btn_raw = '0;
    idle(8);
    check("s6_cnt", int'(q_count), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("s6");
    idle(10);

`ifdef BTN_REQ_TIMEOUT_EN
    n_hi = 0;
    fell = 1'b0;
    btn_raw[3] = 1'b1;
    for (int i = 0; i < 80 && !fell; i++) begin
      @(negedge clk);
      if (i == 9) btn_raw[3] = 1'b0;
      if (jump_req) n_hi++;
      else if (n_hi > 0) begin
        fell = 1'b1;
        check("to_drop", int'(drop_pulse), 1);
      end
    end
    check("to_fell", int'(fell), 1);
    check("to_len", n_hi, TO);
    idle(10);
`endif

    // Random presses, glitches and accepts, with one mid-run reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < N; b++) begin
        if (hcnt[b] > 0) begin
          hcnt[b]--;
          btn_raw[b] = 1'b1;
        end else begin
          btn_raw[b] = 1'b0;
          if ($urandom_range(0, 29) == 0) hcnt[b] = int'($urandom_range(1, 10));
        end
      end
      accept_jump = ($urandom_range(0, 7) == 0);
      rst = (cyc == 1500);
      @(negedge clk);
    end
    rst = 1'b0;
    accept_jump = 1'b0;
    btn_raw = '0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
